arith_core: RTL and testbench
=============================

Name: arith_core

Overview:
- Sequential 8-bit arithmetic unit with a req/ack handshake. Performs add, subtract, multiply and divide on two N-bit operands and returns a 2N-bit result.
- Sits behind the mini-computer's ALU command interface, which drives cmd, operands and req, then waits for ack.
- Add and subtract use a carry-lookahead adder. Multiply is iterative shift-add. Divide is iterative restoring division.

Parameters:
- N, 8, operand width; result width is 2N.

Ports:
- clk, input, 1, system clock; all state changes on rising edge.
- rst, input, 1, synchronous, active-high reset.
- req, input, 1, request; a rising edge (req=1 while previous sampled req=0) starts an operation.
- cmd, input, 2, 00 add, 01 subtract, 10 multiply, 11 divide.
- op1, input, N, first operand / dividend (unsigned).
- op2, input, N, second operand / divisor (unsigned).
- cin, input, 1, carry-in for add, borrow-in for subtract; ignored for multiply and divide.
- alu_out, output, 2N, registered result; holds its value until the next completion.
- cout, output, 1, add carry-out or subtract borrow-out; 0 for multiply and divide.
- ack, output, 1, one-cycle completion pulse; alu_out and cout are valid in the same cycle.
- busy, output, 1, high from the start edge until the ack cycle, inclusive.

Behaviour:
- Reset: alu_out=0, cout=0, ack=0, busy=0, state IDLE, req history register=0. Reset mid-operation aborts the operation with no ack.
- Start detection: req_d registers req every cycle. The start edge E0 is the rising clock edge where req=1, req_d=0 and state=IDLE. At E0, cmd, op1, op2 and cin are captured and busy is set. Operand changes after E0 have no effect.
- Request edges while busy are ignored and are not queued. req held high produces exactly one operation; req must drop and rise again for the next one.
- States: IDLE -> ARITH (add/sub) or ITER (mul/div) -> DONE -> IDLE.
- Add: alu_out = zero-extended (op1 + op2 + cin). Bit N = carry, upper bits = 0. cout = carry.
- Subtract: alu_out = 2N-bit two's complement of (op1 - op2 - cin). cout = 1 when op1 < op2 + cin.
- Add and subtract results are registered at E1. ack is high in the cycle after E1.
- Multiply: unsigned N×N -> 2N product via N shift-add iterations.
- Divide: N restoring iterations. alu_out = {remainder[N-1:0], quotient[N-1:0]}.
- Divide by zero: quotient = all ones, remainder = op1. The iteration count is unchanged.
- Multiply and divide iterate on edges E1..EN. The result is registered at E(N+1). ack is high in the cycle after E(N+1), i.e. a latency of N+2 edges from E0.
- Completion: ack deasserts the next cycle; busy drops with ack. A new start edge is accepted from the first IDLE cycle onward.
- A req rising edge coincident with rst is lost.

Decomposition:
- Shared package arith_pkg:
  - cmd encodings CMD_ADD=2'b00, CMD_SUB=2'b01, CMD_MUL=2'b10, CMD_DIV=2'b11
  - state enum IDLE/ARITH/ITER/DONE
  - default width constant N=8
- One sub-module: carry_lookahead_adder, parameter N, with ports a, b, cin, sum[N-1:0], cout, built from 4-bit lookahead groups.
  - Used directly for add; used with b inverted and carry inverted for subtract.
  - May be reused for the multiply partial-sum and divide trial-subtract steps.

Test Plan:
- add op1=200, op2=100, cin=0 -> alu_out=0x012C, cout=1, ack one cycle after E1.
- sub op1=5, op2=7, cin=0 -> alu_out=0xFFFE, cout=1; sub 9-3 with cin=1 -> 0x0005, cout=0.
- mul 255×255 -> 0xFE01; mul 12×10 -> 0x0078; cout=0; ack exactly N+2 edges after E0; busy high throughout.
- div 200/7 -> 0x041C (remainder 4, quotient 28); div 50/0 -> 0x32FF.
- req held high across two operation lengths -> exactly one ack. Toggling req while busy -> ignored, alu_out unchanged until completion.
- rst asserted midway through a multiply -> next cycle alu_out=0, ack=0, busy=0. A new add then completes correctly.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic unit: command encodings,
// controller states and the default operand width.
package arith_pkg;

  localparam int ARITH_N = 8;

  localparam logic [1:0] CMD_ADD = 2'b00;
  localparam logic [1:0] CMD_SUB = 2'b01;
  localparam logic [1:0] CMD_MUL = 2'b10;
  localparam logic [1:0] CMD_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARITH = 2'b01,
    ITER  = 2'b10,
    DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/carry_lookahead_adder.sv
// N-bit adder built from 4-bit carry-lookahead groups; group carries ripple
// from one group to the next. N must be a multiple of 4.
module carry_lookahead_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int G = N / 4;

  logic [N-1:0] gen_s;
  logic [N-1:0] prop_s;
  logic [G:0]   grp_c_s;

  assign gen_s      = a & b;
  assign prop_s     = a ^ b;
  assign grp_c_s[0] = cin;

  genvar k;
  generate
    for (k = 0; k < G; k++) begin : g_grp
      logic [3:0] gg_s;
      logic [3:0] pp_s;
      logic [4:0] c_s;

      assign gg_s   = gen_s[4*k+3 : 4*k];
      assign pp_s   = prop_s[4*k+3 : 4*k];
      assign c_s[0] = grp_c_s[k];
      assign c_s[1] = gg_s[0] | (pp_s[0] & c_s[0]);
      assign c_s[2] = gg_s[1] | (pp_s[1] & gg_s[0]) | (pp_s[1] & pp_s[0] & c_s[0]);
      assign c_s[3] = gg_s[2] | (pp_s[2] & gg_s[1]) | (pp_s[2] & pp_s[1] & gg_s[0])
                    | (pp_s[2] & pp_s[1] & pp_s[0] & c_s[0]);
      assign c_s[4] = gg_s[3] | (pp_s[3] & gg_s[2]) | (pp_s[3] & pp_s[2] & gg_s[1])
                    | (pp_s[3] & pp_s[2] & pp_s[1] & gg_s[0]) | ((&pp_s) & c_s[0]);

      assign sum[4*k+3 : 4*k] = pp_s ^ c_s[3:0];
      assign grp_c_s[k+1]     = c_s[4];
    end
  endgenerate

  assign cout = grp_c_s[G];

endmodule

// File: rtl/arith_core.sv
// Sequential add/sub/mul/div unit with a req/ack handshake. One shared
// lookahead adder serves add, subtract, multiply partial sums and divide trials.
module arith_core
  import arith_pkg::*;
#(
  parameter int N = ARITH_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req,
  input  logic [1:0]     cmd,
  input  logic [N-1:0]   op1,
  input  logic [N-1:0]   op2,
  input  logic           cin,
  output logic [2*N-1:0] alu_out,
  output logic           cout,
  output logic           ack,
  output logic           busy
);

  localparam int CW = $clog2(N + 1);

  state_t         state_r;
  state_t         state_nxt_s;
  logic           req_d_r;
  logic           start_s;
  logic [1:0]     cmd_r;
  logic [N-1:0]   op1_r;
  logic [N-1:0]   op2_r;
  logic           cin_r;
  logic [N-1:0]   hi_r;
  logic [N-1:0]   lo_r;
  logic [CW-1:0]  cnt_r;
  logic           iter_done_s;

  logic [N-1:0]   cla_a_s;
  logic [N-1:0]   cla_b_s;
  logic           cla_cin_s;
  logic [N-1:0]   cla_sum_s;
  logic           cla_cout_s;

  logic [N-1:0]   hi_nxt_s;
  logic [N-1:0]   lo_nxt_s;
  logic           fit_s;

  assign start_s     = req & ~req_d_r & (state_r == IDLE);
  assign iter_done_s = (cnt_r == CW'(N));

  carry_lookahead_adder #(.N(N)) u_cla (
    .a    (cla_a_s),
    .b    (cla_b_s),
    .cin  (cla_cin_s),
    .sum  (cla_sum_s),
    .cout (cla_cout_s)
  );

  // Controller state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          if (cmd[1]) begin
            state_nxt_s = ITER;
          end else begin
            state_nxt_s = ARITH;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ARITH: state_nxt_s = DONE;
      ITER: begin
        if (iter_done_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = ITER;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Adder operand steering; subtract and divide trials add the inverted divisor
  always_comb begin
    cla_a_s   = op1_r;
    cla_b_s   = op2_r;
    cla_cin_s = cin_r;
    case (cmd_r)
      CMD_ADD: begin
        cla_a_s   = op1_r;
        cla_b_s   = op2_r;
        cla_cin_s = cin_r;
      end
      CMD_SUB: begin
        cla_a_s   = op1_r;
        cla_b_s   = ~op2_r;
        cla_cin_s = ~cin_r;
      end
      CMD_MUL: begin
        cla_a_s   = hi_r;
        cla_cin_s = 1'b0;
        if (lo_r[0]) begin
          cla_b_s = op1_r;
        end else begin
          cla_b_s = '0;
        end
      end
      CMD_DIV: begin
        cla_a_s   = {hi_r[N-2:0], lo_r[N-1]};
        cla_b_s   = ~op2_r;
        cla_cin_s = 1'b1;
      end
      default: begin
        cla_a_s   = op1_r;
        cla_b_s   = op2_r;
        cla_cin_s = cin_r;
      end
    endcase
  end

  // One shift-add or restoring-divide step. A set top bit of the shifted
  // remainder means the trial subtract always fits.
  always_comb begin
    fit_s    = hi_r[N-1] | cla_cout_s;
    hi_nxt_s = hi_r;
    lo_nxt_s = lo_r;
    if (cmd_r == CMD_DIV) begin
      lo_nxt_s = {lo_r[N-2:0], fit_s};
      if (fit_s) begin
        hi_nxt_s = cla_sum_s;
      end else begin
        hi_nxt_s = {hi_r[N-2:0], lo_r[N-1]};
      end
    end else begin
      hi_nxt_s = {cla_cout_s, cla_sum_s[N-1:1]};
      lo_nxt_s = {cla_sum_s[0], lo_r[N-1:1]};
    end
  end

  // Datapath, handshake and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      req_d_r <= 1'b0;
      cmd_r   <= CMD_ADD;
      op1_r   <= '0;
      op2_r   <= '0;
      cin_r   <= 1'b0;
      hi_r    <= '0;
      lo_r    <= '0;
      cnt_r   <= '0;
      alu_out <= '0;
      cout    <= 1'b0;
      ack     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      req_d_r <= req;
      case (state_r)
        IDLE: begin
          if (start_s) begin
            cmd_r <= cmd;
            op1_r <= op1;
            op2_r <= op2;
            cin_r <= cin;
            hi_r  <= '0;
            cnt_r <= '0;
            busy  <= 1'b1;
            if (cmd == CMD_DIV) begin
              lo_r <= op1;
            end else begin
              lo_r <= op2;
            end
          end
        end
        ARITH: begin
          ack <= 1'b1;
          if (cmd_r == CMD_SUB) begin
            alu_out <= {{N{~cla_cout_s}}, cla_sum_s};
            cout    <= ~cla_cout_s;
          end else begin
            alu_out <= {{(N-1){1'b0}}, cla_cout_s, cla_sum_s};
            cout    <= cla_cout_s;
          end
        end
        ITER: begin
          if (iter_done_s) begin
            alu_out <= {hi_r, lo_r};
            cout    <= 1'b0;
            ack     <= 1'b1;
          end else begin
            hi_r  <= hi_nxt_s;
            lo_r  <= lo_nxt_s;
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DONE: begin
          ack  <= 1'b0;
          busy <= 1'b0;
        end
        default: begin
          ack  <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arith_core.sv
// Directed self-checking bench for arith_core: one task per feature, each with
// hand-computed expected results.
module tb_arith_core;

  localparam logic [1:0] C_ADD = 2'b00;
  localparam logic [1:0] C_SUB = 2'b01;
  localparam logic [1:0] C_MUL = 2'b10;
  localparam logic [1:0] C_DIV = 2'b11;

  logic        clk;
  logic        rst;
  logic        req;
  logic [1:0]  cmd;
  logic [7:0]  op1;
  logic [7:0]  op2;
  logic        cin;
  logic [15:0] alu_out;
  logic        cout;
  logic        ack;
  logic        busy;

  int checks;
  int errors;

  arith_core #(.N(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .cmd     (cmd),
    .op1     (op1),
    .op2     (op2),
    .cin     (cin),
    .alu_out (alu_out),
    .cout    (cout),
    .ack     (ack),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one operation from a req rising edge to the cycle after ack.
  // lat counts edges from E0 (inclusive) to the edge that raised ack; -1 on timeout.
  task automatic do_op(input logic [1:0] c, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, output logic [15:0] res, output logic co,
                       output int lat, output bit busy_ok);
    busy_ok = 1'b1;
    lat     = -1;
    res     = 16'h0000;
    co      = 1'b0;
    cmd = c; op1 = a; op2 = b; cin = ci; req = 1'b1;
    @(posedge clk); #1;
    if (busy !== 1'b1) busy_ok = 1'b0;
    op1 = ~a; op2 = ~b;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (ack === 1'b1) begin
        lat = n + 1;
        res = alu_out;
        co  = cout;
        break;
      end
    end
    req = 1'b0;
    @(posedge clk); #1;
    if (ack !== 1'b0 || busy !== 1'b0) busy_ok = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks += 4;
    if (alu_out !== 16'h0000) begin errors++; $display("FAIL reset_alu_out: got %h expected 0000", alu_out); end
    if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", cout); end
    if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", ack); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add;
    logic [15:0] exp_r [3] = '{16'h012C, 16'h01FF, 16'h0003};
    logic        exp_c [3] = '{1'b1, 1'b1, 1'b0};
    logic [7:0]  va    [3] = '{8'd200, 8'd255, 8'd1};
    logic [7:0]  vb    [3] = '{8'd100, 8'd255, 8'd2};
    logic        vc    [3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] res; logic co; int lat; bit bok;
    for (int i = 0; i < 3; i++) begin
      do_op(C_ADD, va[i], vb[i], vc[i], res, co, lat, bok);
      checks += 4;
      if (res !== exp_r[i]) begin errors++; $display("FAIL add_result[%0d]: got %h expected %h", i, res, exp_r[i]); end
      if (co !== exp_c[i]) begin errors++; $display("FAIL add_cout[%0d]: got %b expected %b", i, co, exp_c[i]); end
      if (lat != 2) begin errors++; $display("FAIL add_latency[%0d]: got %0d expected 2", i, lat); end
      if (!bok) begin errors++; $display("FAIL add_busy[%0d]: busy/ack profile wrong", i); end
    end
  endtask

  task automatic test_sub;
    logic [15:0] exp_r [3] = '{16'hFFFE, 16'h0005, 16'hFFFF};
    logic        exp_c [3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0]  va    [3] = '{8'd5, 8'd9, 8'd0};
    logic [7:0]  vb    [3] = '{8'd7, 8'd3, 8'd0};
    logic        vc    [3] = '{1'b0, 1'b1, 1'b1};
    logic [15:0] res; logic co; int lat; bit bok;
    for (int i = 0; i < 3; i++) begin
      do_op(C_SUB, va[i], vb[i], vc[i], res, co, lat, bok);
      checks += 3;
      if (res !== exp_r[i]) begin errors++; $display("FAIL sub_result[%0d]: got %h expected %h", i, res, exp_r[i]); end
      if (co !== exp_c[i]) begin errors++; $display("FAIL sub_borrow[%0d]: got %b expected %b", i, co, exp_c[i]); end
      if (lat != 2) begin errors++; $display("FAIL sub_latency[%0d]: got %0d expected 2", i, lat); end
    end
  endtask

  task automatic test_mul;
    logic [15:0] exp_r [3] = '{16'hFE01, 16'h0078, 16'h0000};
    logic [7:0]  va    [3] = '{8'd255, 8'd12, 8'd0};
    logic [7:0]  vb    [3] = '{8'd255, 8'd10, 8'd77};
    logic [15:0] res; logic co; int lat; bit bok;
    for (int i = 0; i < 3; i++) begin
      do_op(C_MUL, va[i], vb[i], 1'b1, res, co, lat, bok);
      checks += 4;
      if (res !== exp_r[i]) begin errors++; $display("FAIL mul_result[%0d]: got %h expected %h", i, res, exp_r[i]); end
      if (co !== 1'b0) begin errors++; $display("FAIL mul_cout[%0d]: got %b expected 0", i, co); end
      if (lat != 10) begin errors++; $display("FAIL mul_latency[%0d]: got %0d expected 10", i, lat); end
      if (!bok) begin errors++; $display("FAIL mul_busy[%0d]: busy/ack profile wrong", i); end
    end
  endtask

  task automatic test_div;
    logic [15:0] exp_r [3] = '{16'h041C, 16'h32FF, 16'h0700};
    logic [7:0]  va    [3] = '{8'd200, 8'd50, 8'd7};
    logic [7:0]  vb    [3] = '{8'd7, 8'd0, 8'd200};
    logic [15:0] res; logic co; int lat; bit bok;
    for (int i = 0; i < 3; i++) begin
      do_op(C_DIV, va[i], vb[i], 1'b0, res, co, lat, bok);
      checks += 3;
      if (res !== exp_r[i]) begin errors++; $display("FAIL div_result[%0d]: got %h expected %h", i, res, exp_r[i]); end
      if (co !== 1'b0) begin errors++; $display("FAIL div_cout[%0d]: got %b expected 0", i, co); end
      if (lat != 10) begin errors++; $display("FAIL div_latency[%0d]: got %0d expected 10", i, lat); end
    end
  endtask

  task automatic test_req_held;
    int acks = 0;
    cmd = C_MUL; op1 = 8'd3; op2 = 8'd4; cin = 1'b0; req = 1'b1;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) acks++;
    end
    req = 1'b0;
    @(posedge clk); #1;
    checks += 2;
    if (acks != 1) begin errors++; $display("FAIL held_ack_count: got %0d expected 1", acks); end
    if (alu_out !== 16'h000C) begin errors++; $display("FAIL held_result: got %h expected 000c", alu_out); end
  endtask

  task automatic test_toggle_busy;
    int acks = 0;
    cmd = C_MUL; op1 = 8'd6; op2 = 8'd7; cin = 1'b0; req = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < 6; n++) begin
      req = ~req; op1 = 8'hFF; cmd = C_ADD;
      @(posedge clk); #1;
      checks += 1;
      if (alu_out !== 16'h000C || ack !== 1'b0) begin
        errors++; $display("FAIL toggle_hold[%0d]: got %h ack %b expected 000c ack 0", n, alu_out, ack);
      end
    end
    req = 1'b0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) begin
        acks++;
        checks += 1;
        if (alu_out !== 16'h002A) begin errors++; $display("FAIL toggle_result: got %h expected 002a", alu_out); end
      end
    end
    checks += 1;
    if (acks != 1) begin errors++; $display("FAIL toggle_ack_count: got %0d expected 1", acks); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] res; logic co; int lat; bit bok;
    int acks = 0;
    cmd = C_MUL; op1 = 8'd255; op2 = 8'd255; cin = 1'b0; req = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1; req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    checks += 3;
    if (alu_out !== 16'h0000) begin errors++; $display("FAIL midrst_alu_out: got %h expected 0000", alu_out); end
    if (ack !== 1'b0) begin errors++; $display("FAIL midrst_ack: got %b expected 0", ack); end
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) acks++;
    end
    checks += 1;
    if (acks != 0) begin errors++; $display("FAIL midrst_no_ack: got %0d expected 0", acks); end
    do_op(C_ADD, 8'd17, 8'd25, 1'b0, res, co, lat, bok);
    checks += 3;
    if (res !== 16'h002A) begin errors++; $display("FAIL midrst_add_result: got %h expected 002a", res); end
    if (co !== 1'b0) begin errors++; $display("FAIL midrst_add_cout: got %b expected 0", co); end
    if (lat != 2) begin errors++; $display("FAIL midrst_add_latency: got %0d expected 2", lat); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; req = 1'b0; cmd = C_ADD; op1 = 8'h00; op2 = 8'h00; cin = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_div();
    test_req_held();
    test_toggle_busy();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
